// File: rtl/two_digit_countdown.sv
// ---------------------------------------------------------------------------
// two_digit_countdown
//
// Two-digit BCD countdown game timer. It loads a preset value and then
// decrements it once per prescaled tick while enabled. A borrow moves from the
// ones digit into the tens digit. When the count reaches 00 the block latches
// Timeout and emits a single-cycle Timeout_Pulse. It then stays there until a
// reconfig or a reset.
//
// Parameters
//   TICK_DIV    clk cycles per decrement (>= 2)
//   START_TENS  preset tens digit, 0-9
//   START_ONES  preset ones digit, 0-9
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   Timer_Reconfig  in   synchronous reload of the preset (wins over counting)
//   Timer_Enable    in   level: high counts, low pauses with all state held
//   Tens_Digit      out  BCD tens digit
//   Ones_Digit      out  BCD ones digit
//   Timeout         out  high while the timer sits at 00 in DONE
//   Timeout_Pulse   out  one-cycle strobe on entry to DONE
// ---------------------------------------------------------------------------
module two_digit_countdown #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int START_TENS = 6,
    parameter int START_ONES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Timer_Reconfig,
    input  logic       Timer_Enable,
    output logic [3:0] Tens_Digit,
    output logic [3:0] Ones_Digit,
    output logic       Timeout,
    output logic       Timeout_Pulse
);

    localparam int                 PRESC_W     = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(TICK_DIV - 1);
    localparam logic [3:0]         PRESET_TENS = 4'(START_TENS);
    localparam logic [3:0]         PRESET_ONES = 4'(START_ONES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [PRESC_W-1:0] prescaler;
    logic [7:0]         dec_digits;
    logic               at_zero;

    // One BCD step down, saturating at 00 so the digits can never wrap.
    function automatic logic [7:0] bcd_decrement(input logic [3:0] tens,
                                                 input logic [3:0] ones);
        logic [7:0] result;
        if (ones != 4'd0) begin
            result = {tens, ones - 4'd1};
        end else if (tens != 4'd0) begin
            result = {tens - 4'd1, 4'd9};
        end else begin
            result = 8'h00;
        end
        return result;
    endfunction

    assign dec_digits = bcd_decrement(Tens_Digit, Ones_Digit);
    assign at_zero    = (Tens_Digit == 4'd0) && (Ones_Digit == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            prescaler     <= '0;
            Tens_Digit    <= PRESET_TENS;
            Ones_Digit    <= PRESET_ONES;
            Timeout       <= 1'b0;
            Timeout_Pulse <= 1'b0;
        end else if (Timer_Reconfig) begin
            // Reload beats any tick landing on the same edge.
            state         <= S_IDLE;
            prescaler     <= '0;
            Tens_Digit    <= PRESET_TENS;
            Ones_Digit    <= PRESET_ONES;
            Timeout       <= 1'b0;
            Timeout_Pulse <= 1'b0;
        end else begin
            Timeout_Pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    prescaler <= '0;
                    if (Timer_Enable) begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (at_zero) begin
                        // A 00 preset finishes without waiting for a tick.
                        state         <= S_DONE;
                        Timeout       <= 1'b1;
                        Timeout_Pulse <= 1'b1;
                    end else if (Timer_Enable) begin
                        if (prescaler == PRESC_MAX) begin
                            prescaler                <= '0;
                            {Tens_Digit, Ones_Digit} <= dec_digits;
                            if (dec_digits == 8'h00) begin
                                state         <= S_DONE;
                                Timeout       <= 1'b1;
                                Timeout_Pulse <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    Timeout <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_two_digit_countdown.sv
module tb_two_digit_countdown;

    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Timer_Reconfig = 1'b0;
    logic       Timer_Enable = 1'b0;

    logic [3:0] t60, o60, t02, o02, t00, o00;
    logic       to60, tp60, to02, tp02, to00, tp00;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    two_digit_countdown #(.TICK_DIV(TICK), .START_TENS(6), .START_ONES(0)) dut60 (
        .clk(clk), .rst(rst), .Timer_Reconfig(Timer_Reconfig), .Timer_Enable(Timer_Enable),
        .Tens_Digit(t60), .Ones_Digit(o60), .Timeout(to60), .Timeout_Pulse(tp60));

    two_digit_countdown #(.TICK_DIV(TICK), .START_TENS(0), .START_ONES(2)) dut02 (
        .clk(clk), .rst(rst), .Timer_Reconfig(Timer_Reconfig), .Timer_Enable(Timer_Enable),
        .Tens_Digit(t02), .Ones_Digit(o02), .Timeout(to02), .Timeout_Pulse(tp02));

    two_digit_countdown #(.TICK_DIV(TICK), .START_TENS(0), .START_ONES(0)) dut00 (
        .clk(clk), .rst(rst), .Timer_Reconfig(Timer_Reconfig), .Timer_Enable(Timer_Enable),
        .Tens_Digit(t00), .Ones_Digit(o00), .Timeout(to00), .Timeout_Pulse(tp00));

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] digits_of(input int which);
        if (which == 0) return {t60, o60};
        if (which == 1) return {t02, o02};
        return {t00, o00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        Timer_Enable   = 1'b0;
        Timer_Reconfig = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Advance until the chosen timer's digits change, bounded by limit edges.
    task automatic wait_change(input int which, input logic [7:0] prev,
                               input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            step();
            edges++;
            if (digits_of(which) != prev) break;
        end
    endtask

    task automatic test_reset();
        int idle_edges;
        apply_reset();
        checks++;
        if ({t60, o60, to60, tp60} !== {8'h60, 2'b00}) begin
            errors++;
            $display("FAIL reset_dut60: got %h/%b%b expected 60/00", {t60, o60}, to60, tp60);
        end
        checks++;
        if ({t02, o02, to02, tp02} !== {8'h02, 2'b00}) begin
            errors++;
            $display("FAIL reset_dut02: got %h/%b%b expected 02/00", {t02, o02}, to02, tp02);
        end
        checks++;
        if ({t00, o00, to00, tp00} !== {8'h00, 2'b00}) begin
            errors++;
            $display("FAIL reset_dut00: got %h/%b%b expected 00/00", {t00, o00}, to00, tp00);
        end
        // Count down to 47, then hit reset between clock edges.
        Timer_Enable = 1'b1;
        step();
        repeat (13 * TICK) step();
        checks++;
        if ({t60, o60} !== 8'h47) begin
            errors++;
            $display("FAIL reach_47: got %h expected 47", {t60, o60});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({t60, o60, to60} !== {8'h60, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h/%b expected 60/0", {t60, o60}, to60);
        end
        step();
        rst = 1'b0;
        // From IDLE with enable high: one edge to RUN, then TICK edges to 59.
        wait_change(0, 8'h60, 3 * TICK, idle_edges);
        checks++;
        if (idle_edges != TICK + 1 || {t60, o60} !== 8'h59) begin
            errors++;
            $display("FAIL reset_idle: got %0d edges/%h expected %0d edges/59",
                     idle_edges, {t60, o60}, TICK + 1);
        end
    endtask

    task automatic test_countdown();
        int edges;
        int v;
        logic [7:0] cur, exp_d;
        apply_reset();
        v = 60;
        for (int k = 0; k < 51; k++) begin
            v = v - 1;
            exp_q.push_back(to_bcd(v));
        end
        Timer_Enable = 1'b1;
        step();
        cur = {t60, o60};
        while (exp_q.size() > 0) begin
            exp_d = exp_q.pop_front();
            wait_change(0, cur, 3 * TICK, edges);
            checks++;
            if ({t60, o60} !== exp_d) begin
                errors++;
                $display("FAIL countdown_value: got %h expected %h", {t60, o60}, exp_d);
            end
            checks++;
            if (edges != TICK) begin
                errors++;
                $display("FAIL countdown_latency at %h: got %0d edges expected %0d",
                         exp_d, edges, TICK);
            end
            cur = {t60, o60};
        end
        checks++;
        if (to60 !== 1'b0) begin
            errors++;
            $display("FAIL countdown_timeout: got %b expected 0", to60);
        end
    endtask

    task automatic test_timeout();
        int edges;
        int pulses;
        logic [7:0] cur, exp_d;
        apply_reset();
        exp_q.push_back(to_bcd(1));
        exp_q.push_back(to_bcd(0));
        Timer_Enable = 1'b1;
        step();
        cur = {t02, o02};
        while (exp_q.size() > 0) begin
            exp_d = exp_q.pop_front();
            wait_change(1, cur, 3 * TICK, edges);
            checks++;
            if ({t02, o02} !== exp_d || edges != TICK) begin
                errors++;
                $display("FAIL timeout_count: got %h after %0d edges expected %h after %0d",
                         {t02, o02}, edges, exp_d, TICK);
            end
            cur = {t02, o02};
        end
        checks++;
        if ({to02, tp02} !== 2'b11) begin
            errors++;
            $display("FAIL timeout_entry: got %b%b expected 11", to02, tp02);
        end
        step();
        checks++;
        if ({to02, tp02} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_pulse_width: got %b%b expected 10", to02, tp02);
        end
        pulses = 0;
        repeat (3 * TICK) begin
            step();
            if (tp02) pulses++;
        end
        checks++;
        if ({t02, o02, to02} !== {8'h00, 1'b1} || pulses != 0) begin
            errors++;
            $display("FAIL timeout_hold: got %h/%b pulses %0d expected 00/1 pulses 0",
                     {t02, o02}, to02, pulses);
        end
    endtask

    task automatic test_pause();
        apply_reset();
        Timer_Enable = 1'b1;
        step();
        repeat (2) step();
        Timer_Enable = 1'b0;
        repeat (3) step();
        checks++;
        if ({t60, o60} !== 8'h60) begin
            errors++;
            $display("FAIL pause_hold: got %h expected 60", {t60, o60});
        end
        Timer_Enable = 1'b1;
        step();
        checks++;
        if ({t60, o60} !== 8'h60) begin
            errors++;
            $display("FAIL pause_early: got %h expected 60", {t60, o60});
        end
        step();
        checks++;
        if ({t60, o60} !== 8'h59) begin
            errors++;
            $display("FAIL pause_tick: got %h expected 59", {t60, o60});
        end
    endtask

    task automatic test_reconfig();
        int edges60;
        int edges02;
        apply_reset();
        Timer_Enable = 1'b1;
        step();
        repeat (29 * TICK) step();
        checks++;
        if ({t60, o60} !== 8'h31) begin
            errors++;
            $display("FAIL reconfig_reach_31: got %h expected 31", {t60, o60});
        end
        repeat (TICK - 1) step();
        checks++;
        if (to02 !== 1'b1) begin
            errors++;
            $display("FAIL reconfig_pre_done: got %b expected 1", to02);
        end
        // This edge would have ticked 31 -> 30.
        Timer_Reconfig = 1'b1;
        step();
        Timer_Reconfig = 1'b0;
        checks++;
        if ({t60, o60, to60} !== {8'h60, 1'b0}) begin
            errors++;
            $display("FAIL reconfig_tick: got %h/%b expected 60/0", {t60, o60}, to60);
        end
        checks++;
        if ({t02, o02, to02, tp02} !== {8'h02, 2'b00}) begin
            errors++;
            $display("FAIL reconfig_done: got %h/%b%b expected 02/00", {t02, o02}, to02, tp02);
        end
        // Both must restart from IDLE: one edge to RUN plus a full tick.
        wait_change(0, 8'h60, 3 * TICK, edges60);
        checks++;
        if (edges60 != TICK + 1 || {t60, o60} !== 8'h59) begin
            errors++;
            $display("FAIL reconfig_idle60: got %0d edges/%h expected %0d edges/59",
                     edges60, {t60, o60}, TICK + 1);
        end
        checks++;
        edges02 = edges60;
        if ({t02, o02} !== 8'h01) begin
            errors++;
            $display("FAIL reconfig_idle02: got %h after %0d edges expected 01",
                     {t02, o02}, edges02);
        end
    endtask

    task automatic test_zero_preset();
        apply_reset();
        Timer_Enable = 1'b1;
        step();
        checks++;
        if ({t00, o00, to00, tp00} !== {8'h00, 2'b00}) begin
            errors++;
            $display("FAIL zero_run_entry: got %h/%b%b expected 00/00", {t00, o00}, to00, tp00);
        end
        step();
        checks++;
        if ({t00, o00, to00, tp00} !== {8'h00, 2'b11}) begin
            errors++;
            $display("FAIL zero_done: got %h/%b%b expected 00/11", {t00, o00}, to00, tp00);
        end
        step();
        checks++;
        if ({to00, tp00} !== 2'b10) begin
            errors++;
            $display("FAIL zero_single_pulse: got %b%b expected 10", to00, tp00);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_timeout();
        test_pause();
        test_reconfig();
        test_zero_preset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
